board_scanner: RTL and testbench

- Upstream feeder for the per-block shader.
- Tracks the VGA scan position and converts it to board cell column/row and in-block pixel offsets (block_x, block_y).
- Reads the cell code from the board RAM, maps it through a 16-entry palette to a 12-bit in_color, and delivers everything aligned with a valid strobe.
- Sits between the VGA timing generator and the shader/pixel mux.

---
 rtl/board_scanner.sv | 214 +++++++++++++++++++++
 tb/tb_board_scanner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_scanner.sv
// Board scanner: turns VGA scan position into board cell coordinates, reads the cell code
// and maps it to a palette colour. Optional writable palette: BOARD_SCANNER_PALETTE_WR_EN.
module board_scanner #(
    parameter int BLOCK_W  = 26,
    parameter int BLOCK_H  = 32,
    parameter int COLS     = 10,
    parameter int ROWS     = 20,
    parameter int ORIGIN_X = 190,
    parameter int ORIGIN_Y = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        de,
    output logic [7:0]  ram_addr,
    input  logic [3:0]  ram_data,
    output logic [5:0]  block_x,
    output logic [5:0]  block_y,
    output logic [11:0] in_color,
    output logic        in_board,
    output logic        out_valid
`ifdef BOARD_SCANNER_PALETTE_WR_EN
    ,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [11:0] pal_wdata
`endif
);

    localparam logic [9:0] OX       = 10'(ORIGIN_X);
    localparam logic [9:0] OY       = 10'(ORIGIN_Y);
    localparam logic [5:0] BX_LAST  = 6'(BLOCK_W - 1);
    localparam logic [5:0] BY_LAST  = 6'(BLOCK_H - 1);
    localparam logic [3:0] COL_LAST = 4'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [7:0] COLS8    = 8'(COLS);

    function automatic logic [11:0] palette_rom(input logic [3:0] code);
        case (code)
            4'd0:    palette_rom = 12'h000;
            4'd1:    palette_rom = 12'h0FF;
            4'd2:    palette_rom = 12'h00F;
            4'd3:    palette_rom = 12'hF80;
            4'd4:    palette_rom = 12'hFF0;
            4'd5:    palette_rom = 12'h0F0;
            4'd6:    palette_rom = 12'h80F;
            4'd7:    palette_rom = 12'hF00;
            4'd8:    palette_rom = 12'h888;
            default: palette_rom = 12'hFFF;
        endcase
    endfunction

    logic [9:0] px;
    logic [5:0] bx_cnt;
    logic [3:0] col;
    logic       h_in;
    logic [9:0] py;
    logic [5:0] by_cnt;
    logic [4:0] row;
    logic [7:0] row_base;
    logic       v_in;
    logic       first_line;

    logic       h_hit;
    logic       pix_h;
    logic [5:0] pix_bx;
    logic [3:0] pix_col;
    logic       pix_on;

    logic       s0_de;
    logic       s0_in;
    logic [5:0] s0_bx;
    logic [5:0] s0_by;
    logic [11:0] pal_rd;

    // Coordinates of the pixel presented this cycle; the board's first column starts at px==ORIGIN_X
    always_comb begin
        h_hit   = (px == OX);
        pix_h   = !line_start && (h_in || h_hit);
        pix_bx  = h_hit ? 6'd0 : bx_cnt;
        pix_col = h_hit ? 4'd0 : col;
        pix_on  = de && pix_h && v_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px     <= '0;
            bx_cnt <= '0;
            col    <= '0;
            h_in   <= 1'b0;
        end else if (line_start) begin
            px     <= '0;
            bx_cnt <= '0;
            col    <= '0;
            h_in   <= 1'b0;
        end else if (de) begin
            px <= px + 10'd1;
            if (pix_h) begin
                if (pix_bx == BX_LAST) begin
                    bx_cnt <= '0;
                    if (pix_col == COL_LAST) begin
                        col  <= pix_col;
                        h_in <= 1'b0;
                    end else begin
                        col  <= pix_col + 4'd1;
                        h_in <= 1'b1;
                    end
                end else begin
                    bx_cnt <= pix_bx + 6'd1;
                    col    <= pix_col;
                    h_in   <= 1'b1;
                end
            end
        end
    end

    // The first line_start of a frame only consumes first_line; later ones advance the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            py         <= '0;
            by_cnt     <= '0;
            row        <= '0;
            row_base   <= '0;
            v_in       <= 1'b0;
            first_line <= 1'b1;
        end else if (frame_start) begin
            py         <= '0;
            by_cnt     <= '0;
            row        <= '0;
            row_base   <= '0;
            v_in       <= (ORIGIN_Y == 0);
            first_line <= !line_start;
        end else if (line_start) begin
            if (first_line) begin
                first_line <= 1'b0;
            end else begin
                py <= py + 10'd1;
                if (v_in) begin
                    if (by_cnt == BY_LAST) begin
                        by_cnt <= '0;
                        if (row == ROW_LAST) begin
                            v_in <= 1'b0;
                        end else begin
                            row      <= row + 5'd1;
                            row_base <= row_base + COLS8;
                        end
                    end else begin
                        by_cnt <= by_cnt + 6'd1;
                    end
                end else if (py + 10'd1 == OY) begin
                    v_in     <= 1'b1;
                    by_cnt   <= '0;
                    row      <= '0;
                    row_base <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            s0_de    <= 1'b0;
            s0_in    <= 1'b0;
            s0_bx    <= '0;
            s0_by    <= '0;
        end else begin
            s0_de <= de;
            s0_in <= pix_on;
            s0_bx <= pix_bx;
            s0_by <= by_cnt;
            if (pix_on) begin
                ram_addr <= row_base + {4'd0, pix_col};
            end
        end
    end

    // Outputs line up with ram_data, which the RAM returns in this same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            in_board  <= 1'b0;
            block_x   <= '0;
            block_y   <= '0;
        end else begin
            out_valid <= s0_de;
            in_board  <= s0_in;
            block_x   <= s0_in ? s0_bx : 6'd0;
            block_y   <= s0_in ? s0_by : 6'd0;
        end
    end

`ifdef BOARD_SCANNER_PALETTE_WR_EN
    logic [11:0] pal_q [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= palette_rom(4'(i));
            end
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_wdata;
        end
    end

    assign pal_rd = pal_q[ram_data];
`else
    assign pal_rd = palette_rom(ram_data);
`endif

    assign in_color = in_board ? pal_rd : 12'h000;

endmodule

// File: tb/tb_board_scanner.sv
// Bench for board_scanner: palette vector table plus scoreboard-checked scan lines, frames
// and a mid-line reset. Exercises the writable palette when BOARD_SCANNER_PALETTE_WR_EN is defined.
module tb_board_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        de = 1'b0;
    logic [7:0]  ram_addr;
    logic [3:0]  ram_data = 4'd0;
    logic [5:0]  block_x;
    logic [5:0]  block_y;
    logic [11:0] in_color;
    logic        in_board;
    logic        out_valid;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = 4'd0;
    logic [11:0] pal_wdata = 12'd0;

    board_scanner dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start), .de(de),
        .ram_addr(ram_addr), .ram_data(ram_data), .block_x(block_x), .block_y(block_y),
        .in_color(in_color), .in_board(in_board), .out_valid(out_valid)
`ifdef BOARD_SCANNER_PALETTE_WR_EN
        , .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [11:0] color;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        ib;
        logic [5:0]  bx;
        logic [5:0]  by;
        logic [11:0] col;
    } beat_t;

    vec_t        vecs [16];
    logic [11:0] pal_ref [16];
    logic [3:0]  mem [256];
    beat_t       q [$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          line_no = -1;
    bit          blind = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_data <= mem[ram_addr];
    end

    // Scoreboard: every out_valid beat must match the head of the queue in value and cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_beat: got out_valid=1 at cycle %0d, required no beat", cyc);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    if (cyc != e.cyc || in_board !== e.ib || block_x !== e.bx ||
                        block_y !== e.by || in_color !== e.col) begin
                        fails++;
                        $display("[TB] FAIL beat: got cyc=%0d ib=%0b bx=%0d by=%0d col=%h, required cyc=%0d ib=%0b bx=%0d by=%0d col=%h",
                                 cyc, in_board, block_x, block_y, in_color, e.cyc, e.ib, e.bx, e.by, e.col);
                    end
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                tests++;
                fails++;
                $display("[TB] FAIL missing_beat: got out_valid=0 at cycle %0d, required beat for cycle %0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        line_no = -1;
        blind = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
        check_output("drain", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    // Drive n de pixels of the current line; optionally reset at pixel rst_at or write the palette at wr_at
    task automatic apply_stimulus(input int n, input int rst_at, input int wr_at);
        bit chk_prev = 1'b0;
        int prev_addr = 0;
        for (int p = 0; p < n; p++) begin
            beat_t b;
            bit on;
            int addr;
            tick();
            if (chk_prev) check_output("ram_addr", 64'(ram_addr), 64'(prev_addr));
            chk_prev = 1'b0;
            de = 1'b1;
            pal_we = 1'b0;
            on = !blind && line_no >= 0 && line_no < 640 && p >= 190 && p < 450;
            addr = on ? (line_no / 32) * 10 + (p - 190) / 26 : 0;
            b.cyc = cyc + 2;
            b.ib  = on;
            b.bx  = on ? 6'((p - 190) % 26) : 6'd0;
            b.by  = on ? 6'(line_no % 32) : 6'd0;
            b.col = on ? pal_ref[mem[addr]] : 12'h000;
            if (on && wr_at >= 0 && mem[addr] == 4'd1 && p >= wr_at - 1) b.col = 12'h123;
            q.push_back(b);
            if (on && (p - 190) % 26 == 13) begin
                chk_prev = 1'b1;
                prev_addr = addr;
            end
            if (p == wr_at) begin
                pal_we = 1'b1;
                pal_addr = 4'd1;
                pal_wdata = 12'h123;
            end
            if (p == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_output("midline_reset_outputs",
                                {30'd0, out_valid, in_board, block_x, block_y, in_color, ram_addr}, 64'd0);
                q.delete();
                blind = 1'b1;
                de = 1'b0;
                chk_prev = 1'b0;
                tick();
                rst_n = 1'b1;
                break;
            end
        end
        tick();
        if (chk_prev) check_output("ram_addr", 64'(ram_addr), 64'(prev_addr));
        de = 1'b0;
        pal_we = 1'b0;
    endtask

    task automatic next_line(input int n, input int rst_at, input int wr_at);
        tick();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        line_no++;
        if (n > 0) begin
            apply_stimulus(n, rst_at, wr_at);
            drain();
        end
    endtask

    initial begin
        vecs[0]  = '{4'd0,  12'h000};
        vecs[1]  = '{4'd1,  12'h0FF};
        vecs[2]  = '{4'd2,  12'h00F};
        vecs[3]  = '{4'd3,  12'hF80};
        vecs[4]  = '{4'd4,  12'hFF0};
        vecs[5]  = '{4'd5,  12'h0F0};
        vecs[6]  = '{4'd6,  12'h80F};
        vecs[7]  = '{4'd7,  12'hF00};
        vecs[8]  = '{4'd8,  12'h888};
        vecs[9]  = '{4'd9,  12'hFFF};
        vecs[10] = '{4'd10, 12'hFFF};
        vecs[11] = '{4'd11, 12'hFFF};
        vecs[12] = '{4'd12, 12'hFFF};
        vecs[13] = '{4'd13, 12'hFFF};
        vecs[14] = '{4'd14, 12'hFFF};
        vecs[15] = '{4'd15, 12'hFFF};
        for (int i = 0; i < 16; i++) pal_ref[vecs[i].code] = vecs[i].color;
        for (int a = 0; a < 256; a++) mem[a] = 4'd4;

        repeat (3) tick();
        check_output("reset_outputs",
                     {30'd0, out_valid, in_board, block_x, block_y, in_color, ram_addr}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Line 0 across the full 800-pixel width with every cell yellow
        start_frame();
        next_line(800, -1, -1);

        // Address-coded board: rows 0, 1, 19 and the line after the board
        for (int a = 0; a < 256; a++) mem[a] = 4'(a % 16);
        start_frame();
        next_line(460, -1, -1);
        for (int l = 1; l < 32; l++) next_line(0, -1, -1);
        next_line(460, -1, -1);
        for (int l = 33; l < 639; l++) next_line(0, -1, -1);
        next_line(460, -1, -1);
        next_line(460, -1, -1);

        // Reset in the middle of line 100, blind lines, then a clean frame
        start_frame();
        for (int l = 0; l < 100; l++) next_line(0, -1, -1);
        next_line(460, 250, -1);
        next_line(460, -1, -1);
        next_line(460, -1, -1);
        start_frame();
        next_line(460, -1, -1);

        // Palette table: one code at a time on cell (0,0)
        for (int i = 0; i < 16; i++) begin
            for (int a = 0; a < 256; a++) mem[a] = vecs[i].code;
            start_frame();
            next_line(200, -1, -1);
        end

`ifdef BOARD_SCANNER_PALETTE_WR_EN
        for (int a = 0; a < 256; a++) mem[a] = 4'd1;
        start_frame();
        next_line(200, -1, 195);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
